// File: rtl/mem_stage_if.sv
// Data-cache request/response bundle between the memory stage and the data cache.
interface mem_stage_if #(
  parameter int WORD_W = 32
);
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data-cache handshake FSM, MEM/WB register
// and the EX/MEM forwarding source.
module mem_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              flush,
  input  logic [WORD_W-1:0] nPC_in,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              regWr_in,
  input  logic [1:0]        regSel_in,
  input  logic [REG_W-1:0]  regDst_in,
  input  logic [WORD_W-1:0] ALUOut_in,
  input  logic [WORD_W-1:0] store_in,
  mem_stage_if.master       dcache,
  output logic              stall,
  output logic              fwdWr,
  output logic [REG_W-1:0]  fwdDst,
  output logic [WORD_W-1:0] fwdData,
  output logic              regWr_wb,
  output logic [REG_W-1:0]  regDst_wb,
  output logic [WORD_W-1:0] wdat_wb
);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    word_t      npc;
    logic       dren;
    logic       dwen;
    logic       regwr;
    logic [1:0] regsel;
    regbit_t    regdst;
    word_t      aluout;
    word_t      store;
  } exmem_t;

  state_t  state_reg, state_next;
  exmem_t  exmem_reg, exmem_load;
  word_t   ldbuf_reg, ldbuf_next;
  logic    regwr_wb_reg;
  regbit_t regdst_wb_reg;
  word_t   wdat_wb_reg, wdat_sel;
  logic    advance;
  logic    load_is_mem;

  assign stall   = (state_reg == WAIT);
  assign advance = ihit & ~stall;

  // A flushed slot is an all-zero bubble: no enables, no data.
  always_comb begin
    exmem_load = '0;
    if (!flush) begin
      exmem_load.npc    = nPC_in;
      exmem_load.dren   = dREN_in;
      exmem_load.dwen   = dWEN_in;
      exmem_load.regwr  = regWr_in;
      exmem_load.regsel = regSel_in;
      exmem_load.regdst = regDst_in;
      exmem_load.aluout = ALUOut_in;
      exmem_load.store  = store_in;
    end
  end

  assign load_is_mem = exmem_load.dren | exmem_load.dwen;

  always_comb begin
    state_next = state_reg;
    ldbuf_next = ldbuf_reg;
    case (state_reg)
      IDLE, HOLD: begin
        if (advance) begin
          state_next = load_is_mem ? WAIT : IDLE;
        end
      end
      WAIT: begin
        if (dcache.dhit) begin
          state_next = HOLD;
          if (exmem_reg.dren) begin
            ldbuf_next = dcache.dmemload;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wdat_sel = exmem_reg.aluout;
    case (exmem_reg.regsel)
      2'd1:    wdat_sel = ldbuf_reg;
      2'd2:    wdat_sel = exmem_reg.npc;
      default: wdat_sel = exmem_reg.aluout;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= IDLE;
      exmem_reg     <= '0;
      ldbuf_reg     <= '0;
      regwr_wb_reg  <= 1'b0;
      regdst_wb_reg <= '0;
      wdat_wb_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ldbuf_reg <= ldbuf_next;
      if (advance) begin
        exmem_reg     <= exmem_load;
        regwr_wb_reg  <= exmem_reg.regwr;
        regdst_wb_reg <= exmem_reg.regdst;
        wdat_wb_reg   <= wdat_sel;
      end
    end
  end

  // Requests are only live while waiting; HOLD keeps the captured data quiet.
  assign dcache.dmemREN   = exmem_reg.dren & (state_reg == WAIT);
  assign dcache.dmemWEN   = exmem_reg.dwen & (state_reg == WAIT);
  assign dcache.dmemaddr  = exmem_reg.aluout;
  assign dcache.dmemstore = exmem_reg.store;

  // Load data is not available in EX/MEM, so loads are never forwarded from here.
  assign fwdWr   = exmem_reg.regwr & (exmem_reg.regsel != 2'd1);
  assign fwdDst  = exmem_reg.regdst;
  assign fwdData = exmem_reg.aluout;

  assign regWr_wb  = regwr_wb_reg;
  assign regDst_wb = regdst_wb_reg;
  assign wdat_wb   = wdat_wb_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB entries are queued when an
// instruction enters EX/MEM and compared when the following advance retires it.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] nPC_in = '0;
  logic        dREN_in = 1'b0;
  logic        dWEN_in = 1'b0;
  logic        regWr_in = 1'b0;
  logic [1:0]  regSel_in = '0;
  logic [4:0]  regDst_in = '0;
  logic [31:0] ALUOut_in = '0;
  logic [31:0] store_in = '0;
  logic        stall, fwdWr, regWr_wb;
  logic [4:0]  fwdDst, regDst_wb;
  logic [31:0] fwdData, wdat_wb;

  mem_stage_if #(.WORD_W(32)) dif ();

  mem_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
    .nPC_in(nPC_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in), .regWr_in(regWr_in),
    .regSel_in(regSel_in), .regDst_in(regDst_in), .ALUOut_in(ALUOut_in),
    .store_in(store_in), .dcache(dif), .stall(stall), .fwdWr(fwdWr),
    .fwdDst(fwdDst), .fwdData(fwdData), .regWr_wb(regWr_wb),
    .regDst_wb(regDst_wb), .wdat_wb(wdat_wb)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [4:0]  dst;
    logic [31:0] dat;
  } wb_t;

  wb_t         sb_q[$];
  logic [31:0] planned_load = '0;
  int          hit_delay = 0;
  logic [31:0] inflight_load = '0;
  int          inflight_delay = 0;
  logic        adv_prev = 1'b0;
  int          wait_cnt = 0;

  function automatic wb_t model_entry();
    wb_t e;
    e = '0;
    if (!flush) begin
      e.wr  = regWr_in;
      e.dst = regDst_in;
      case (regSel_in)
        2'd1:    e.dat = planned_load;
        2'd2:    e.dat = nPC_in;
        default: e.dat = ALUOut_in;
      endcase
    end
    return e;
  endfunction

  // Monitor: retire the oldest expected entry on each advance, queue the new one.
  always @(negedge CLK) begin : monitor
    wb_t e;
    if (!nRST) begin
      sb_q.delete();
      sb_q.push_back('0);
      adv_prev = 1'b0;
    end else begin
      if (adv_prev) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("wb_regWr", {31'd0, regWr_wb}, {31'd0, e.wr});
          check("wb_regDst", {27'd0, regDst_wb}, {27'd0, e.dst});
          check("wb_wdat", wdat_wb, e.dat);
          $display("wb retire wr=%0d dst=%0d dat=%h", regWr_wb, regDst_wb, wdat_wb);
        end
      end
      adv_prev = ihit && !stall;
      if (adv_prev) begin
        sb_q.push_back(model_entry());
        if (!flush && (dREN_in || dWEN_in)) begin
          inflight_load  = planned_load;
          inflight_delay = hit_delay;
        end
      end
    end
  end

  // Cache model: answer the outstanding request after inflight_delay wait cycles.
  always @(posedge CLK) begin
    #1;
    if (dif.dmemREN || dif.dmemWEN) begin
      if (wait_cnt == inflight_delay) begin
        dif.dhit     = 1'b1;
        dif.dmemload = inflight_load;
      end else begin
        dif.dhit     = 1'b0;
        dif.dmemload = ~inflight_load;
      end
      wait_cnt++;
    end else begin
      dif.dhit     = 1'b0;
      dif.dmemload = 32'hA5A5_5A5A;
      wait_cnt     = 0;
    end
  end

  task automatic drive_op(input logic ren, input logic wen, input logic wr,
                          input logic [1:0] sel, input logic [4:0] dst,
                          input logic [31:0] alu, input logic [31:0] st,
                          input logic [31:0] npc, input logic [31:0] ld,
                          input int dly, input logic fl);
    int n;
    dREN_in = ren; dWEN_in = wen; regWr_in = wr; regSel_in = sel;
    regDst_in = dst; ALUOut_in = alu; store_in = st; nPC_in = npc;
    planned_load = ld; hit_delay = dly; flush = fl; ihit = 1'b1;
    n = 0;
    @(negedge CLK);
    while (stall && n < 100) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 100) check("adv_timeout", 32'd1, 32'd0);
    @(posedge CLK);
    #1;
    ihit = 1'b0;
    flush = 1'b0;
  endtask

  task automatic count_wait(output int ren_c, output int wen_c, output int st_c);
    ren_c = 0; wen_c = 0; st_c = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (dif.dmemREN) ren_c++;
      if (dif.dmemWEN) wen_c++;
      if (stall) st_c++;
      if (!stall) break;
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_dmemREN"}, {31'd0, dif.dmemREN}, 32'd0);
    check({pfx, "_dmemWEN"}, {31'd0, dif.dmemWEN}, 32'd0);
    check({pfx, "_dmemaddr"}, dif.dmemaddr, 32'd0);
    check({pfx, "_dmemstore"}, dif.dmemstore, 32'd0);
    check({pfx, "_stall"}, {31'd0, stall}, 32'd0);
    check({pfx, "_fwdWr"}, {31'd0, fwdWr}, 32'd0);
    check({pfx, "_fwdDst"}, {27'd0, fwdDst}, 32'd0);
    check({pfx, "_fwdData"}, fwdData, 32'd0);
    check({pfx, "_regWr_wb"}, {31'd0, regWr_wb}, 32'd0);
    check({pfx, "_regDst_wb"}, {27'd0, regDst_wb}, 32'd0);
    check({pfx, "_wdat_wb"}, wdat_wb, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rc, wc, sc, kind, idle, dly;
    logic fl;
    logic [31:0] a, d;
    dif.dhit = 1'b0;
    dif.dmemload = '0;
    repeat (2) @(negedge CLK);
    check_all_zero("rst");
    @(posedge CLK); #1; nRST = 1'b1;

    // ALU op, then a nop to retire it into MEM/WB
    drive_op(0, 0, 1, 2'd0, 5'd8, 32'h10, 32'h0, 32'h4, 32'h0, 0, 0);
    check("alu_fwdData", fwdData, 32'h10);
    check("alu_fwdDst", {27'd0, fwdDst}, 32'd8);
    check("alu_fwdWr", {31'd0, fwdWr}, 32'd1);
    check("alu_stall", {31'd0, stall}, 32'd0);
    drive_op(0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h8, 32'h0, 0, 0);

    // Load with the hit in the third wait cycle
    drive_op(1, 0, 1, 2'd1, 5'd9, 32'h100, 32'h0, 32'hC, 32'hDEAD_BEEF, 2, 0);
    check("ld_dmemaddr", dif.dmemaddr, 32'h100);
    check("ld_fwdWr", {31'd0, fwdWr}, 32'd0);
    count_wait(rc, wc, sc);
    check("ld_ren_cycles", rc, 32'd3);
    check("ld_stall_cycles", sc, 32'd3);
    check("ld_hold_ren", {31'd0, dif.dmemREN}, 32'd0);
    drive_op(0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h10, 32'h0, 0, 0);

    // Store with immediate hit
    drive_op(0, 1, 0, 2'd0, 5'd3, 32'h200, 32'h1234, 32'h14, 32'h0, 0, 0);
    check("st_dmemWEN", {31'd0, dif.dmemWEN}, 32'd1);
    check("st_dmemstore", dif.dmemstore, 32'h1234);
    check("st_dmemaddr", dif.dmemaddr, 32'h200);
    count_wait(rc, wc, sc);
    check("st_wen_cycles", wc, 32'd1);
    check("st_stall_cycles", sc, 32'd1);

    // HOLD with ihit low, then a back-to-back load
    drive_op(1, 0, 1, 2'd1, 5'd10, 32'h300, 32'h0, 32'h18, 32'hCAFE_0001, 1, 0);
    count_wait(rc, wc, sc);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("hold_ren", {31'd0, dif.dmemREN}, 32'd0);
      check("hold_stall", {31'd0, stall}, 32'd0);
    end
    drive_op(1, 0, 1, 2'd1, 5'd11, 32'h304, 32'h0, 32'h1C, 32'hCAFE_0002, 0, 0);
    check("b2b_ren", {31'd0, dif.dmemREN}, 32'd1);
    check("b2b_addr", dif.dmemaddr, 32'h304);
    count_wait(rc, wc, sc);

    // Flush held across WAIT: access completes, next advance loads a bubble
    drive_op(1, 0, 1, 2'd1, 5'd12, 32'h400, 32'h0, 32'h20, 32'h0BAD_0000, 2, 0);
    flush = 1'b1; ihit = 1'b1;
    count_wait(rc, wc, sc);
    check("fl_ren_cycles", rc, 32'd3);
    @(posedge CLK); #1;
    ihit = 1'b0; flush = 1'b0;
    check("fl_fwdWr", {31'd0, fwdWr}, 32'd0);
    check("fl_ren", {31'd0, dif.dmemREN}, 32'd0);
    check("fl_stall", {31'd0, stall}, 32'd0);
    check("fl_fwdDst", {27'd0, fwdDst}, 32'd0);

    // Random mix of ALU, load, store and link ops
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      dly  = $urandom_range(0, 3);
      fl   = ($urandom_range(0, 7) == 0);
      a    = $urandom;
      d    = $urandom;
      case (kind)
        0: drive_op(0, 0, 1, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0, 5'($urandom_range(1, 31)), a, d, 32'h1000 + i, d, dly, fl);
        1: drive_op(1, 0, 1, 2'd1, 5'($urandom_range(1, 31)), a, 32'h0, 32'h1000 + i, d, dly, fl);
        2: drive_op(0, 1, 0, 2'd0, 5'($urandom_range(0, 31)), a, d, 32'h1000 + i, 32'h0, dly, fl);
        default: drive_op(0, 0, 1, 2'd2, 5'd31, a, d, 32'h2000 + i, d, dly, fl);
      endcase
      idle = $urandom_range(0, 2);
      repeat (idle) @(posedge CLK);
      #1;
    end
    drive_op(0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Asynchronous reset in the middle of an outstanding load
    drive_op(1, 0, 1, 2'd1, 5'd13, 32'h500, 32'h0, 32'h24, 32'h1111_2222, 20, 0);
    check("rstw_ren", {31'd0, dif.dmemREN}, 32'd1);
    #2; nRST = 1'b0;
    #1; check_all_zero("rstw");
    @(negedge CLK);
    @(posedge CLK); #1; nRST = 1'b1;
    @(negedge CLK);
    check("rstw_post_stall", {31'd0, stall}, 32'd0);
    check("rstw_post_ren", {31'd0, dif.dmemREN}, 32'd0);
    drive_op(0, 0, 1, 2'd0, 5'd14, 32'h77, 32'h0, 32'h28, 32'h0, 0, 0);
    drive_op(0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h2C, 32'h0, 0, 0);
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
